note_synth: RTL

//  Downstream of the recorder/playback datapath: consumes one 32-bit note word per beat and synthesises audio.

---
 rtl/note_pkg.sv | 50 +++++
 rtl/note_synth_if.sv | 25 ++
 rtl/note_synth_string_voice.sv | 49 ++++
 rtl/note_synth.sv | 121 ++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared constants, types and helpers for the six-string note synthesiser.
package note_pkg;

    localparam int unsigned NUM_STRINGS = 6;
    localparam int unsigned NUM_FRETS   = 5;
    localparam int unsigned NUM_PITCH   = 29;
    localparam int unsigned NOTE_W      = 32;
    localparam int unsigned FRET_W      = 3;
    localparam int unsigned PITCH_W     = 5;
    localparam int unsigned HP_W        = 19;
    localparam int unsigned ENV_W       = 8;
    localparam int unsigned MIX_W       = 12;
    localparam int unsigned MIX_SHIFT   = 4;
    localparam int unsigned AUDIO_W     = MIX_W + MIX_SHIFT;

    typedef logic        [HP_W-1:0]    hp_t;
    typedef logic        [ENV_W-1:0]   env_t;
    typedef logic        [FRET_W-1:0]  fret_t;
    typedef logic        [PITCH_W-1:0] pitch_t;
    typedef logic signed [MIX_W-1:0]   mix_t;
    typedef logic signed [AUDIO_W-1:0] audio_t;

    localparam env_t ENV_MAX = '1;

    // Open-string semitone offsets from E2: E2 A2 D3 G3 B3 E4.
    localparam pitch_t OPEN_SEMI [NUM_STRINGS] = '{
        5'd0, 5'd5, 5'd10, 5'd15, 5'd19, 5'd24
    };

    // Square-wave half period in 50 MHz clk cycles, index 0 = E2 .. 28 = G#4.
    localparam hp_t HALF_PERIOD [NUM_PITCH] = '{
        19'd303374, 19'd286346, 19'd270274, 19'd255105, 19'd240787,
        19'd227273, 19'd214517, 19'd202477, 19'd191113, 19'd180386,
        19'd170262, 19'd160706, 19'd151686, 19'd143173, 19'd135137,
        19'd127553, 19'd120394, 19'd113636, 19'd107258, 19'd101238,
        19'd95556,  19'd90193,  19'd85131,  19'd80353,  19'd75843,
        19'd71586,  19'd67569,  19'd63776,  19'd60197
    };

    // Highest set fret wins; returns 0 when no fret bit is set.
    function automatic fret_t top_fret(input logic [NUM_FRETS-1:0] frets);
        fret_t f;
        f = '0;
        for (int unsigned i = 0; i < NUM_FRETS; i++) begin
            if (frets[i]) f = FRET_W'(i);
        end
        return f;
    endfunction

endpackage

// File: rtl/note_synth_if.sv
// Note input / PCM output bundle between the playback datapath, synth and codec.
interface note_synth_if;
    import note_pkg::*;

    logic                   beat;
    logic                   note_valid;
    logic [NOTE_W-1:0]      note_in;
    logic                   mute;
    logic                   audio_ready;
    audio_t                 audio_out;
    logic                   audio_valid;
    logic                   overrun;
    logic [NUM_STRINGS-1:0] voice_active;

    modport master (
        output beat, note_valid, note_in, mute, audio_ready,
        input  audio_out, audio_valid, overrun, voice_active
    );

    modport slave (
        input  beat, note_valid, note_in, mute, audio_ready,
        output audio_out, audio_valid, overrun, voice_active
    );

endinterface

// File: rtl/note_synth_string_voice.sv
// One string: square-wave oscillator with a linearly decaying 8-bit envelope.
module string_voice
    import note_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic i_strike,
    input  hp_t  i_half_period,
    input  logic i_decay_en,
    output logic o_square,
    output env_t o_env
);

    hp_t  r_phase;
    hp_t  r_half;
    logic r_square;
    env_t r_env;

    // Strike restarts the voice; otherwise oscillate and decay while the envelope is nonzero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_phase  <= '0;
            r_half   <= '0;
            r_square <= 1'b0;
            r_env    <= '0;
        end else if (i_strike) begin
            r_phase  <= '0;
            r_half   <= i_half_period;
            r_square <= 1'b1;
            r_env    <= ENV_MAX;
        end else begin
            if (i_decay_en && (r_env != '0)) begin
                r_env <= r_env - ENV_W'(1);
            end
            if (r_env != '0) begin
                if (r_phase == r_half - HP_W'(1)) begin
                    r_phase  <= '0;
                    r_square <= ~r_square;
                end else begin
                    r_phase <= r_phase + HP_W'(1);
                end
            end
        end
    end

    assign o_square = r_square;
    assign o_env    = r_env;

endmodule

// File: rtl/note_synth.sv
// Six-voice note synthesiser: fret decode, sample/decay dividers, mixer and PCM handshake.
module note_synth
    import note_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV    = 1042,
    parameter int unsigned DECAY_SAMPLES = 96
) (
    input  logic         clk,
    input  logic         resetn,
    note_synth_if.slave  bus
);

    localparam int unsigned DIV_W = (SAMPLE_DIV    > 1) ? $clog2(SAMPLE_DIV)    : 1;
    localparam int unsigned DEC_W = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;

    logic [DIV_W-1:0]       r_div;
    logic [DEC_W-1:0]       r_dcnt;
    logic                   w_tick;
    logic                   w_decay_en;

    logic [NUM_FRETS-1:0]   w_frets;
    logic [NUM_STRINGS-1:0] w_strike;
    hp_t                    w_half_period [NUM_STRINGS];
    logic [NUM_STRINGS-1:0] w_square;
    env_t                   w_env [NUM_STRINGS];
    logic [NUM_STRINGS-1:0] w_env_nz;
    mix_t                   w_sum;
    audio_t                 w_sample;

    audio_t                 r_audio_out;
    logic                   r_audio_valid;
    logic                   r_overrun;
    logic [NUM_STRINGS-1:0] r_voice_active;

    logic                   w_unused;

    assign w_tick     = (r_div == DIV_W'(SAMPLE_DIV - 1));
    assign w_decay_en = w_tick && (r_dcnt == DEC_W'(DECAY_SAMPLES - 1));
    assign w_unused   = &{1'b0, bus.note_in[NOTE_W-1:NUM_STRINGS*NUM_FRETS]};

    // Free-running sample divider and tick-based decay divider.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_div  <= '0;
            r_dcnt <= '0;
        end else begin
            if (w_tick) begin
                r_div <= '0;
                if (w_decay_en) r_dcnt <= '0;
                else            r_dcnt <= r_dcnt + DEC_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // Per-string strike detect and pitch lookup from the highest set fret.
    always_comb begin
        w_strike      = '0;
        w_half_period = '{default: '0};
        w_frets       = '0;
        for (int unsigned s = 0; s < NUM_STRINGS; s++) begin
            for (int unsigned f = 0; f < NUM_FRETS; f++) begin
                w_frets[f] = bus.note_in[NUM_STRINGS*f + s];
            end
            w_strike[s]      = bus.beat & bus.note_valid & (|w_frets);
            w_half_period[s] = HALF_PERIOD[OPEN_SEMI[s] + pitch_t'(top_fret(w_frets))];
        end
    end

    for (genvar gs = 0; gs < NUM_STRINGS; gs++) begin : g_voice
        string_voice u_voice (
            .clk           (clk),
            .resetn        (resetn),
            .i_strike      (w_strike[gs]),
            .i_half_period (w_half_period[gs]),
            .i_decay_en    (w_decay_en),
            .o_square      (w_square[gs]),
            .o_env         (w_env[gs])
        );
    end

    // Signed mix of all voices; silent voices contribute nothing.
    always_comb begin
        w_sum    = '0;
        w_env_nz = '0;
        for (int unsigned s = 0; s < NUM_STRINGS; s++) begin
            if (w_env[s] != '0) begin
                w_env_nz[s] = 1'b1;
                if (w_square[s]) w_sum = w_sum + mix_t'(w_env[s]);
                else             w_sum = w_sum - mix_t'(w_env[s]);
            end
        end
        w_sample = bus.mute ? '0 : audio_t'({w_sum, {MIX_SHIFT{1'b0}}});
    end

    // Output sample register with valid/ready handshake; a new tick always overwrites.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_audio_out    <= '0;
            r_audio_valid  <= 1'b0;
            r_overrun      <= 1'b0;
            r_voice_active <= '0;
        end else begin
            r_voice_active <= w_env_nz;
            r_overrun      <= w_tick & r_audio_valid & ~bus.audio_ready;
            if (w_tick) begin
                r_audio_out   <= w_sample;
                r_audio_valid <= 1'b1;
            end else if (r_audio_valid & bus.audio_ready) begin
                r_audio_valid <= 1'b0;
            end
        end
    end

    assign bus.audio_out    = r_audio_out;
    assign bus.audio_valid  = r_audio_valid;
    assign bus.overrun      = r_overrun;
    assign bus.voice_active = r_voice_active;

endmodule
